// File: rtl/vram_arbiter.sv
// Fixed-priority arbiter for NCH requesters sharing one external VRAM bus.
// Optional bank bit on ma_out when VRAM_ARBITER_BANK_EN is defined.
module vram_arbiter #(
    parameter int AW      = 13,
    parameter int DW      = 8,
    parameter int NCH     = 3,
    parameter int STB_CYC = 1,
    parameter int LOCK_CH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NCH-1:0]    req,
    input  logic [NCH-1:0]    we,
    input  logic [NCH*AW-1:0] addr,
    input  logic [NCH*DW-1:0] wdata,
    input  logic              lock,
    input  logic [DW-1:0]     md_in,
`ifdef VRAM_ARBITER_BANK_EN
    input  logic              bank_wr,
    input  logic              bank_d,
    output logic [AW:0]       ma_out,
`else
    output logic [AW-1:0]     ma_out,
`endif
    output logic [NCH-1:0]    ack,
    output logic [DW-1:0]     rdata,
    output logic [DW-1:0]     md_out,
    output logic              md_oe,
    output logic              mcs_n,
    output logic              moe_n,
    output logic              mwr_n,
    output logic              busy
);

    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD
    } state_t;

    state_t         r_state;
    logic [3:0]     r_cnt;
    logic           r_we;
    logic [IW-1:0]  r_win;
`ifdef VRAM_ARBITER_BANK_EN
    logic           r_bank;
`endif

    logic [NCH-1:0] w_lock_sel;
    logic [NCH-1:0] w_req_eff;
    logic           w_win_vld;
    logic [IW-1:0]  w_win_idx;
    logic [AW-1:0]  w_win_addr;
    logic [DW-1:0]  w_win_data;
    logic           w_win_we;
    logic           w_lock_we;
    logic           w_lockout;

    // A channel being acked this cycle still holds req; mask it so it is not re-granted.
    always_comb begin
        w_win_vld  = 1'b0;
        w_win_idx  = '0;
        w_win_addr = '0;
        w_win_data = '0;
        w_win_we   = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            w_lock_sel[i] = (i == LOCK_CH);
        end
        w_req_eff = req & ~ack & ~(w_lock_sel & {NCH{lock}});
        for (int i = NCH - 1; i >= 0; i--) begin
            if (w_req_eff[i]) begin
                w_win_vld  = 1'b1;
                w_win_idx  = IW'(i);
                w_win_addr = addr[i*AW +: AW];
                w_win_data = wdata[i*DW +: DW];
                w_win_we   = we[i];
            end
        end
        w_lock_we = |(we & w_lock_sel);
        w_lockout = (r_state == S_IDLE) && lock && (|(req & ~ack & w_lock_sel)) && !w_win_vld;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_win   <= '0;
            ack     <= '0;
            rdata   <= '0;
            ma_out  <= '0;
            md_out  <= '0;
            md_oe   <= 1'b0;
            mcs_n   <= 1'b1;
            moe_n   <= 1'b1;
            mwr_n   <= 1'b1;
            busy    <= 1'b0;
`ifdef VRAM_ARBITER_BANK_EN
            r_bank  <= 1'b0;
`endif
        end else begin
            ack <= '0;
`ifdef VRAM_ARBITER_BANK_EN
            if (bank_wr) begin
                r_bank <= bank_d;
            end
`endif
            case (r_state)
                S_IDLE, S_HOLD: begin
                    if (w_win_vld) begin
                        r_state <= S_SETUP;
                        r_we    <= w_win_we;
                        r_win   <= w_win_idx;
                        busy    <= 1'b1;
                        mcs_n   <= 1'b0;
`ifdef VRAM_ARBITER_BANK_EN
                        ma_out  <= {r_bank, w_win_addr};
`else
                        ma_out  <= w_win_addr;
`endif
                        md_oe   <= w_win_we;
                        if (w_win_we) begin
                            md_out <= w_win_data;
                        end
                    end else begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                        md_oe   <= 1'b0;
                        // Locked-out channel is answered without touching the bus.
                        if (w_lockout) begin
                            ack <= w_lock_sel;
                            if (!w_lock_we) begin
                                rdata <= '1;
                            end
                        end
                    end
                end
                S_SETUP: begin
                    r_state <= S_STROBE;
                    r_cnt   <= 4'(STB_CYC - 1);
                    if (r_we) begin
                        mwr_n <= 1'b0;
                    end else begin
                        moe_n <= 1'b0;
                    end
                end
                S_STROBE: begin
                    if (r_cnt == 4'd0) begin
                        r_state    <= S_HOLD;
                        mcs_n      <= 1'b1;
                        moe_n      <= 1'b1;
                        mwr_n      <= 1'b1;
                        ack[r_win] <= 1'b1;
                        if (!r_we) begin
                            rdata <= md_in;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: one instance with STB_CYC=1, one with STB_CYC=3.
// Bank tests run only when VRAM_ARBITER_BANK_EN is defined.
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  req = '0;
    logic [2:0]  we = '0;
    logic [38:0] addr = '0;
    logic [23:0] wdata = '0;
    logic        lock = 1'b0;
    logic [7:0]  md_in = '0;
`ifdef VRAM_ARBITER_BANK_EN
    logic        bank_wr = 1'b0;
    logic        bank_d = 1'b0;
    logic [13:0] ma_out, ma_out3;
`else
    logic [12:0] ma_out, ma_out3;
`endif
    logic [2:0]  ack, ack3;
    logic [7:0]  rdata, rdata3, md_out, md_out3;
    logic        md_oe, mcs_n, moe_n, mwr_n, busy;
    logic        md_oe3, mcs_n3, moe_n3, mwr_n3, busy3;

    int checks = 0;
    int errors = 0;

    vram_arbiter #(.AW(13), .DW(8), .NCH(3), .STB_CYC(1), .LOCK_CH(2)) u_dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .lock(lock), .md_in(md_in),
`ifdef VRAM_ARBITER_BANK_EN
        .bank_wr(bank_wr), .bank_d(bank_d),
`endif
        .ma_out(ma_out), .ack(ack), .rdata(rdata), .md_out(md_out), .md_oe(md_oe),
        .mcs_n(mcs_n), .moe_n(moe_n), .mwr_n(mwr_n), .busy(busy)
    );

    vram_arbiter #(.AW(13), .DW(8), .NCH(3), .STB_CYC(3), .LOCK_CH(2)) u_dut3 (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .lock(lock), .md_in(md_in),
`ifdef VRAM_ARBITER_BANK_EN
        .bank_wr(bank_wr), .bank_d(bank_d),
`endif
        .ma_out(ma_out3), .ack(ack3), .rdata(rdata3), .md_out(md_out3), .md_oe(md_oe3),
        .mcs_n(mcs_n3), .moe_n(moe_n3), .mwr_n(mwr_n3), .busy(busy3)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        req = '0;
        for (int i = 0; i < 10; i++) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({ack, rdata, md_out, md_oe, mcs_n, moe_n, mwr_n, busy} !== {3'b000, 8'h00, 8'h00, 5'b01110}) begin
            errors++;
            $display("FAIL reset_outputs got %h expected %h",
                     {ack, rdata, md_out, md_oe, mcs_n, moe_n, mwr_n, busy}, {3'b000, 8'h00, 8'h00, 5'b01110});
        end
        checks++;
        if (ma_out !== '0) begin
            errors++;
            $display("FAIL reset_ma_out got %h expected 0", ma_out);
        end
        checks++;
        if ({busy3, mcs_n3, ack3} !== 5'b01000) begin
            errors++;
            $display("FAIL reset_dut3 got %b expected 01000", {busy3, mcs_n3, ack3});
        end
        reset = 1'b0;
    endtask

    task automatic test_single_read();
        addr[12:0] = 13'h1ABC;
        we         = 3'b000;
        md_in      = 8'h5A;
        req        = 3'b001;
        tick();
        checks++;
        if ({mcs_n, moe_n, mwr_n, busy} !== 4'b0111) begin
            errors++;
            $display("FAIL rd_setup_strobes got %b expected 0111", {mcs_n, moe_n, mwr_n, busy});
        end
        checks++;
        if (ma_out !== 13'h1ABC) begin
            errors++;
            $display("FAIL rd_setup_addr got %h expected 1abc", ma_out);
        end
        tick();
        checks++;
        if ({mcs_n, moe_n, mwr_n} !== 3'b001) begin
            errors++;
            $display("FAIL rd_strobe got %b expected 001", {mcs_n, moe_n, mwr_n});
        end
        tick();
        checks++;
        if ({ack, rdata} !== {3'b001, 8'h5A}) begin
            errors++;
            $display("FAIL rd_ack_data got %h expected %h", {ack, rdata}, {3'b001, 8'h5A});
        end
        checks++;
        if ({mcs_n, moe_n, mwr_n} !== 3'b111) begin
            errors++;
            $display("FAIL rd_hold_strobes got %b expected 111", {mcs_n, moe_n, mwr_n});
        end
        req = '0;
        tick();
        checks++;
        if ({ack, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL rd_idle got %b expected 0000", {ack, busy});
        end
        settle();
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        logic prev = 1'b1;
        addr[12:0]   = 13'h0010;
        addr[38:26]  = 13'h0020;
        wdata[7:0]   = 8'h11;
        wdata[23:16] = 8'h22;
        we  = 3'b101;
        req = 3'b101;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (mwr_n === 1'b0 && prev === 1'b1) pulses++;
            prev = mwr_n;
            case (c)
                1: begin
                    checks++;
                    if ({ma_out, md_out, md_oe} !== {13'h0010, 8'h11, 1'b1}) begin
                        errors++;
                        $display("FAIL b2b_ch0_setup got %h expected %h", {ma_out, md_out, md_oe}, {13'h0010, 8'h11, 1'b1});
                    end
                end
                3: begin
                    checks++;
                    if ({ack, md_oe, mcs_n} !== 5'b00111) begin
                        errors++;
                        $display("FAIL b2b_ch0_hold got %b expected 00111", {ack, md_oe, mcs_n});
                    end
                    req[0] = 1'b0;
                end
                4: begin
                    checks++;
                    if ({ma_out, md_out, mcs_n, busy, ack} !== {13'h0020, 8'h22, 1'b0, 1'b1, 3'b000}) begin
                        errors++;
                        $display("FAIL b2b_ch2_setup got %h expected %h",
                                 {ma_out, md_out, mcs_n, busy, ack}, {13'h0020, 8'h22, 1'b0, 1'b1, 3'b000});
                    end
                end
                6: begin
                    checks++;
                    if (ack !== 3'b100) begin
                        errors++;
                        $display("FAIL b2b_ch2_ack got %b expected 100", ack);
                    end
                    req[2] = 1'b0;
                end
                7: begin
                    checks++;
                    if ({busy, md_oe} !== 2'b00) begin
                        errors++;
                        $display("FAIL b2b_idle got %b expected 00", {busy, md_oe});
                    end
                end
                default: ;
            endcase
        end
        checks++;
        if (pulses !== 2) begin
            errors++;
            $display("FAIL b2b_wr_pulses got %0d expected 2", pulses);
        end
        settle();
    endtask

    task automatic test_lockout();
        int mcs_low = 0;
        addr[38:26] = 13'h0100;
        we   = 3'b000;
        lock = 1'b1;
        req  = 3'b100;
        tick();
        if (mcs_n === 1'b0) mcs_low++;
        checks++;
        if ({ack, rdata, busy} !== {3'b100, 8'hFF, 1'b0}) begin
            errors++;
            $display("FAIL lockout_ack got %h expected %h", {ack, rdata, busy}, {3'b100, 8'hFF, 1'b0});
        end
        req = '0;
        tick();
        if (mcs_n === 1'b0) mcs_low++;
        checks++;
        if (ack !== 3'b000) begin
            errors++;
            $display("FAIL lockout_ack_pulse got %b expected 000", ack);
        end
        tick();
        if (mcs_n === 1'b0) mcs_low++;
        checks++;
        if (mcs_low !== 0) begin
            errors++;
            $display("FAIL lockout_no_bus got %0d expected 0", mcs_low);
        end
        lock = 1'b0;
        settle();
    endtask

    task automatic test_lock_during_strobe();
        addr[38:26] = 13'h0100;
        we    = 3'b000;
        md_in = 8'h3C;
        lock  = 1'b0;
        req   = 3'b100;
        tick();
        checks++;
        if (mcs_n !== 1'b0) begin
            errors++;
            $display("FAIL lds_setup got %b expected 0", mcs_n);
        end
        tick();
        lock = 1'b1;
        checks++;
        if ({mcs_n, moe_n} !== 2'b00) begin
            errors++;
            $display("FAIL lds_strobe got %b expected 00", {mcs_n, moe_n});
        end
        tick();
        checks++;
        if ({ack, rdata} !== {3'b100, 8'h3C}) begin
            errors++;
            $display("FAIL lds_complete got %h expected %h", {ack, rdata}, {3'b100, 8'h3C});
        end
        req = '0;
        tick();
        req = 3'b100;
        tick();
        checks++;
        if ({ack, rdata, mcs_n} !== {3'b100, 8'hFF, 1'b1}) begin
            errors++;
            $display("FAIL lds_relock got %h expected %h", {ack, rdata, mcs_n}, {3'b100, 8'hFF, 1'b1});
        end
        req = '0;
        tick();
        lock = 1'b0;
        settle();
    endtask

    task automatic test_long_strobe();
        int low = 0;
        int oe_cnt = 0;
        addr[25:13]  = 13'h0AAA;
        wdata[15:8]  = 8'hC3;
        we  = 3'b010;
        req = 3'b010;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (mwr_n3 === 1'b0) low++;
            if (md_oe3 === 1'b1) oe_cnt++;
            case (c)
                1: begin
                    checks++;
                    if ({md_oe3, mcs_n3, mwr_n3, ma_out3, md_out3} !== {3'b101, 13'h0AAA, 8'hC3}) begin
                        errors++;
                        $display("FAIL long_setup got %h expected %h",
                                 {md_oe3, mcs_n3, mwr_n3, ma_out3, md_out3}, {3'b101, 13'h0AAA, 8'hC3});
                    end
                end
                4: begin
                    checks++;
                    if ({mwr_n3, ack3} !== 4'b0000) begin
                        errors++;
                        $display("FAIL long_last_strobe got %b expected 0000", {mwr_n3, ack3});
                    end
                end
                5: begin
                    checks++;
                    if ({ack3, md_oe3, mwr_n3} !== 5'b01011) begin
                        errors++;
                        $display("FAIL long_hold got %b expected 01011", {ack3, md_oe3, mwr_n3});
                    end
                    req = '0;
                end
                6: begin
                    checks++;
                    if ({ack3, md_oe3} !== 4'b0000) begin
                        errors++;
                        $display("FAIL long_idle got %b expected 0000", {ack3, md_oe3});
                    end
                end
                default: ;
            endcase
        end
        checks++;
        if (low !== 3) begin
            errors++;
            $display("FAIL long_wr_cycles got %0d expected 3", low);
        end
        checks++;
        if (oe_cnt !== 5) begin
            errors++;
            $display("FAIL long_oe_cycles got %0d expected 5", oe_cnt);
        end
        settle();
    endtask

    task automatic test_reset_mid();
        addr[12:0] = 13'h0055;
        wdata[7:0] = 8'h99;
        we  = 3'b001;
        req = 3'b001;
        tick();
        tick();
        checks++;
        if ({mwr_n, md_oe} !== 2'b01) begin
            errors++;
            $display("FAIL rstmid_strobe got %b expected 01", {mwr_n, md_oe});
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({mcs_n, moe_n, mwr_n, md_oe, busy, ack} !== 8'b11100000) begin
            errors++;
            $display("FAIL rstmid_outputs got %b expected 11100000", {mcs_n, moe_n, mwr_n, md_oe, busy, ack});
        end
        checks++;
        if ({ma_out, md_out} !== '0) begin
            errors++;
            $display("FAIL rstmid_bus got %h expected 0", {ma_out, md_out});
        end
        reset = 1'b0;
        req   = '0;
        tick();
        checks++;
        if ({ack, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL rstmid_no_ack got %b expected 0000", {ack, busy});
        end
        settle();
    endtask

`ifdef VRAM_ARBITER_BANK_EN
    task automatic test_bank();
        bank_wr = 1'b1;
        bank_d  = 1'b1;
        tick();
        bank_wr    = 1'b0;
        addr[12:0] = 13'h0005;
        we  = 3'b000;
        req = 3'b001;
        tick();
        checks++;
        if (ma_out !== 14'h2005) begin
            errors++;
            $display("FAIL bank_set got %h expected 2005", ma_out);
        end
        tick();
        tick();
        req = '0;
        tick();
        req     = 3'b001;
        bank_wr = 1'b1;
        bank_d  = 1'b0;
        tick();
        bank_wr = 1'b0;
        checks++;
        if (ma_out !== 14'h2005) begin
            errors++;
            $display("FAIL bank_same_cycle got %h expected 2005", ma_out);
        end
        tick();
        tick();
        req = '0;
        tick();
        req = 3'b001;
        tick();
        checks++;
        if (ma_out !== 14'h0005) begin
            errors++;
            $display("FAIL bank_next_grant got %h expected 0005", ma_out);
        end
        settle();
    endtask
`endif

    initial begin
        test_reset();
        test_single_read();
        test_back_to_back();
        test_lockout();
        test_lock_during_strobe();
        test_long_strobe();
        test_reset_mid();
`ifdef VRAM_ARBITER_BANK_EN
        test_bank();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
